// File: rtl/ipv4_pkg.sv
// rtl/ipv4_pkg.sv - IPv4 receive constants, header word indices and FSM encoding
package ipv4_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 2;

  localparam logic [15:0] IPV4_HEAD_N = 16'd20;
  localparam logic [3:0]  IPV4_VER    = 4'd4;
  localparam logic [3:0]  IPV4_IHL    = 4'd5;
  localparam logic [7:0]  PROTO_UDP   = 8'd17;

  localparam logic [3:0] W_VER    = 4'd0;
  localparam logic [3:0] W_TLEN   = 4'd1;
  localparam logic [3:0] W_FRAG   = 4'd3;
  localparam logic [3:0] W_PROTO  = 4'd4;
  localparam logic [3:0] W_CSUM   = 4'd5;
  localparam logic [3:0] W_DST_HI = 4'd8;
  localparam logic [3:0] W_DST_LO = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_HEAD    = 4'b0010,
    S_PAYLOAD = 4'b0100,
    S_DRAIN   = 4'b1000
  } state_t;

  // Beats carry the first wire byte in the low lane; header words are big-endian.
  function automatic logic [15:0] hdr_word(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/ipv4_rx_if.sv
// rtl/ipv4_rx_if.sv - beat stream in from the MAC rx and payload stream out to the UDP rx
interface ipv4_rx_if;
  import ipv4_pkg::*;

  logic              cancel_i;
  logic              valid_i;
  logic              start_i;
  logic              term_i;
  logic [DATA_W-1:0] data_i;
  logic [LEN_W-1:0]  len_i;

  logic              cancel_o;
  logic              valid_o;
  logic              start_o;
  logic              term_o;
  logic [LEN_W-1:0]  term_len_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic              ip_cs_err_o;

  modport master (
    output cancel_i, valid_i, start_i, term_i, data_i, len_i,
    input  cancel_o, valid_o, start_o, term_o, term_len_o, data_o, len_o, ip_cs_err_o
  );

  modport slave (
    input  cancel_i, valid_i, start_i, term_i, data_i, len_i,
    output cancel_o, valid_o, start_o, term_o, term_len_o, data_o, len_o, ip_cs_err_o
  );

endinterface

// File: rtl/ipv4_csum.sv
// rtl/ipv4_csum.sv - ones-complement header checksum accumulator with end-around carry
module ipv4_csum (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  output logic        ok
);

  logic [15:0] acc;
  logic [15:0] base;
  logic [16:0] sum;
  logic [15:0] folded;

  // Folding the carry back cannot overflow again: 0xFFFE + 1 is the worst case.
  always_comb begin
    base   = clr ? 16'h0000 : acc;
    sum    = {1'b0, base} + {1'b0, data};
    folded = sum[15:0] + {15'b0, sum[16]};
  end

  assign ok = (folded == 16'hFFFF);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc <= 16'h0000;
    end else if (en) begin
      acc <= folded;
    end else if (clr) begin
      acc <= 16'h0000;
    end
  end

endmodule

// File: rtl/ipv4_rx.sv
// rtl/ipv4_rx.sv - IPv4 header parse/filter/strip with Total Length trim, zero-latency payload pass-through
module ipv4_rx
  import ipv4_pkg::*;
#(
  parameter logic [31:0] DST_ADDR = 32'hC0A8_0102,
  parameter logic [7:0]  PROTO    = PROTO_UDP
) (
  input  logic      clk,
  input  logic      nreset,
  ipv4_rx_if.slave  bus
);

  state_t      state, state_n;
  logic [3:0]  wcnt, wcnt_n;
  logic        discard, discard_n;
  logic        cs_err, cs_err_n;
  logic        started, started_n;
  logic [15:0] remaining, rem_n;

  logic        csum_clr, csum_en, csum_ok;
  logic [15:0] w;
  logic        rem_le;
  logic [1:0]  len_trim;
  logic        payload_open;
  logic        valid_o, start_o, term_o, cancel_o;

  ipv4_csum u_csum (
    .clk    (clk),
    .nreset (nreset),
    .clr    (csum_clr),
    .en     (csum_en),
    .data   (w),
    .ok     (csum_ok)
  );

  always_comb begin
    w            = hdr_word(bus.data_i);
    rem_le       = remaining <= {14'b0, bus.len_i};
    len_trim     = rem_le ? remaining[1:0] : bus.len_i;
    payload_open = (state == S_PAYLOAD) && started && !discard;
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    discard_n = discard;
    cs_err_n  = cs_err;
    started_n = started;
    rem_n     = remaining;
    csum_clr  = 1'b0;
    csum_en   = 1'b0;
    valid_o   = 1'b0;
    start_o   = 1'b0;
    term_o    = 1'b0;
    cancel_o  = 1'b0;

    if (bus.cancel_i) begin
      state_n  = S_IDLE;
      cancel_o = payload_open;
    end else if (bus.valid_i && bus.start_i) begin
      // A start in any state opens a new frame; an open payload is aborted downstream.
      cancel_o  = payload_open;
      state_n   = bus.term_i ? S_IDLE : S_HEAD;
      wcnt_n    = 4'd1;
      discard_n = (w[15:12] != IPV4_VER) || (w[11:8] != IPV4_IHL);
      cs_err_n  = 1'b0;
      started_n = 1'b0;
      rem_n     = 16'h0000;
      csum_clr  = 1'b1;
      csum_en   = 1'b1;
    end else if (bus.valid_i) begin
      case (state)
        S_HEAD: begin
          csum_en = 1'b1;
          wcnt_n  = wcnt + 4'd1;
          case (wcnt)
            W_TLEN: begin
              if (w < IPV4_HEAD_N) begin
                discard_n = 1'b1;
                rem_n     = 16'h0000;
              end else begin
                rem_n = w - IPV4_HEAD_N;
              end
            end
            W_FRAG:   if (w[13] || (w[12:0] != 13'd0)) discard_n = 1'b1;
            W_PROTO:  if (w[7:0] != PROTO) discard_n = 1'b1;
            W_DST_HI: if (w != DST_ADDR[31:16]) discard_n = 1'b1;
            W_DST_LO: begin
              if (w != DST_ADDR[15:0]) discard_n = 1'b1;
              cs_err_n = !csum_ok;
            end
            W_VER, W_CSUM: ;
            default: ;
          endcase
          if (wcnt == W_DST_LO) begin
            if (bus.term_i)                          state_n = S_IDLE;
            else if (discard_n || remaining == 16'h0) state_n = S_DRAIN;
            else                                     state_n = S_PAYLOAD;
          end else if (bus.term_i) begin
            state_n = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (bus.term_i && !rem_le) begin
            cancel_o = payload_open;
            state_n  = S_IDLE;
          end else begin
            valid_o   = !discard;
            start_o   = !discard && !started;
            term_o    = !discard && (bus.term_i || rem_le);
            started_n = 1'b1;
            rem_n     = remaining - {14'b0, len_trim};
            if (bus.term_i)  state_n = S_IDLE;
            else if (rem_le) state_n = S_DRAIN;
          end
        end
        S_DRAIN: if (bus.term_i) state_n = S_IDLE;
        default: ;
      endcase
    end
  end

  assign bus.valid_o     = valid_o;
  assign bus.start_o     = start_o;
  assign bus.term_o      = term_o;
  assign bus.cancel_o    = cancel_o;
  assign bus.len_o       = valid_o ? len_trim : 2'd0;
  assign bus.term_len_o  = term_o ? len_trim : 2'd0;
  assign bus.data_o      = valid_o ? bus.data_i : 16'h0000;
  assign bus.ip_cs_err_o = cs_err;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      wcnt      <= 4'd0;
      discard   <= 1'b0;
      cs_err    <= 1'b0;
      started   <= 1'b0;
      remaining <= 16'h0000;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      discard   <= discard_n;
      cs_err    <= cs_err_n;
      started   <= started_n;
      remaining <= rem_n;
    end
  end

endmodule

// File: doc/ipv4_rx.md
Name: ipv4_rx

Overview:
- IPv4 receive stage directly upstream of the UDP rx stage.
- Consumes the Ethernet-payload beat stream from the MAC rx. Parses and strips the fixed 20-byte IPv4 header, verifies the header checksum, filters on version/IHL/protocol/destination address/fragmentation, and trims Ethernet padding using Total Length.
- Emits the IP payload beat stream with start/term/len and a checksum-error flag for the UDP stage.

Parameters:
- DATA_W, 16, beat width in bits; only 16 is supported.
- LEN_W, 2, width of byte-count fields; value = number of valid bytes in the beat (1..2); valid bytes are always the low bytes.
- DST_ADDR, 32'hC0A8_0102, local IPv4 address; packets to any other address are discarded.
- PROTO, 8'd17, accepted protocol number (UDP).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- cancel_i  in  1  upstream abort of current frame
- valid_i  in  1  beat valid
- start_i  in  1  first beat of frame (qualified by valid_i)
- term_i  in  1  last beat of frame (qualified by valid_i)
- data_i  in  DATA_W  beat data; data_i[7:0] is the first wire byte
- len_i  in  LEN_W  valid bytes in beat
- cancel_o  out  1  abort of a payload already started downstream
- valid_o  out  1  payload beat valid
- start_o  out  1  first payload beat
- term_o  out  1  last payload beat
- term_len_o  out  LEN_W  valid bytes on term beat (equals len_o when term_o)
- data_o  out  DATA_W  payload data (data_i pass-through)
- len_o  out  LEN_W  valid bytes, trimmed to Total Length
- ip_cs_err_o  out  1  header checksum failed; stable from start_o through term_o

Behaviour:
- Datapath is combinational pass-through; latency 0 beats. All state is in flops reset asynchronously by nreset.
- Reset values: state=IDLE, all outputs 0, discard=0, cs_err=0.
- Header word k (0..9) = {data_i[7:0], data_i[15:8]}:
  - w0 = ver/IHL/TOS; w1 = Total Length; w3 = flags/fragment offset; w4 = TTL/proto; w5 = checksum; w8–w9 = destination address.
- States are one-hot: IDLE, HEAD, PAYLOAD, DRAIN. Transitions occur only on valid_i, except cancel_i, which acts on any cycle.
  - IDLE -> HEAD: valid_i & start_i. That beat is w0 and word counter := 1.
  - HEAD -> PAYLOAD: after w9 is accepted.
  - HEAD -> IDLE: term_i arrives before w9 (runt). Nothing is output.
  - PAYLOAD -> IDLE: term_o asserted (upstream term_i or remaining bytes reach 0) while term_i is also present.
  - PAYLOAD -> DRAIN: remaining bytes reach 0 before term_i (padding follows).
  - DRAIN -> IDLE: on term_i. All DRAIN beats are suppressed.
  - Any state -> IDLE: on cancel_i.
- Discard flag: set in HEAD if any of the following holds:
  - ver != 4 or IHL != 5;
  - proto != PROTO;
  - MF=1 or fragment offset != 0;
  - Total Length < 20;
  - w8–w9 != DST_ADDR.
  - While discard=1, valid_o, start_o and term_o stay 0 for the rest of the frame.
- Checksum: 17-bit accumulator, ones-complement add with end-around carry over w0..w9.
  - Result must equal 16'hFFFF; otherwise cs_err=1.
  - cs_err is registered on w9 and drives ip_cs_err_o for the whole payload.
  - A checksum error does not discard the frame; the UDP stage drops it.
- Remaining counter (16 bit): loaded with Total Length − 20 on w1 acceptance, adjusted when the header ends. Decrements by len_o per payload beat and never underflows.
  - len_o = min(len_i, remaining).
  - term_o = valid_o & (term_i | remaining ≤ len_i).
- Zero-length payload (Total Length = 20): no payload beats; frame goes straight to DRAIN or IDLE.
- start_o: first valid_o beat of the packet.
- Truncation: term_i arrives in PAYLOAD with remaining > len_i:
  - that beat is output with valid_o=0;
  - cancel_o=1 for that cycle, if start_o has already been issued;
  - return to IDLE.
- cancel_i in PAYLOAD (not discard, start issued): cancel_o=1 the same cycle.
- start_i & valid_i seen in a non-IDLE state: treat as implicit cancel plus new frame; assert cancel_o if a payload is open.

Decomposition:
- Package ipv4_pkg holds:
  - IPV4_HEAD_N=20, IPV4_VER=4, IPV4_IHL=5, PROTO_UDP=17;
  - header word index constants;
  - the state one-hot encoding.
- Sub-module ipv4_csum: accumulator with clr/en/data inputs, end-around carry, and an ok output.

Test Plan:
- Valid UDP packet, Total Length=28, good checksum, 60-byte Ethernet payload -> 4 payload beats; start_o on the first, term_o on the 4th with len_o=2, ip_cs_err_o=0; padding beats produce no valid_o.
- Same packet with checksum word corrupted by 0x0001 -> payload forwarded, ip_cs_err_o=1 from start_o through term_o.
- Odd Total Length=29 -> 5th beat has len_o=term_len_o=1 and term_o=1 while len_i=2; the rest are drained.
- Destination 192.168.1.3, proto=6, or MF=1 (each case separate) -> valid_o stays 0 for the whole frame; the next good frame passes normally.
- cancel_i on the 2nd payload beat -> cancel_o=1 that cycle, FSM back to IDLE; a frame started next cycle is parsed correctly.
- nreset asserted mid-HEAD, then released -> all outputs 0 immediately; the next start_i frame is accepted with no residual discard or cs_err.
